ex_mem_stage: RTL
=================

// Module: ex_mem_stage
// PURPOSE
//  Execute-to-memory pipeline stage, directly downstream of the ALU. Consumes the ALU result/zero
//  flag plus decoded control, resolves branches/jumps, and registers the EX/MEM payload behind a
//  valid/ready handshake. Drives a one-cycle redirect to fetch for every taken control transfer.
// PARAMETERS
//  XLEN        32  datapath width (pc, alu result, store data)
//  REG_ADDR_W  5   destination register index width
// PORTS
//  clk            in   1        single clock, rising edge
//  rst_n          in   1        asynchronous, active-low reset
//  flush          in   1        kill all held and incoming beats
//  in_valid       in   1        EX beat present
//  in_ready       out  1        stage can accept
//  alu_o          in   XLEN     ALU result
//  alu_zero       in   1        ALU result == 0
//  pc, imm        in   XLEN     instruction pc, sign-extended immediate
//  rs2_data       in   XLEN     store data
//  rd             in   REG_ADDR_W destination register
//  br_funct3      in   3        branch condition (RV32I B-type funct3)
//  is_branch, is_jal, is_jalr, mem_read, mem_write, reg_write  in  1 each
//  out_valid      out  1        EX/MEM beat valid
//  out_ready      in   1        memory stage accepts
//  out_result     out  XLEN     alu_o, or pc+4 when is_jal|is_jalr
//  out_store_data out  XLEN     rs2_data
//  out_rd         out  REG_ADDR_W
//  out_mem_read, out_mem_write, out_reg_write  out  1 each
//  redirect_valid out  1        taken branch/jump pulse
//  redirect_pc    out  XLEN     redirect target
// BEHAVIOUR
//  - Reset: out_valid=0, redirect_valid=0, all payload/redirect_pc=0; in_ready=1 after reset.
//  - Accept: in_valid & in_ready & !flush. Emit: out_valid & out_ready. Latency 1 cycle.
//  - Branch taken (ALU does SUB/SLT/SLTU upstream): 000 zero; 001 !zero; 100 alu_o[0];
//    101 !alu_o[0]; 110 alu_o[0]; 111 !alu_o[0]; 010/011 never taken.
//  - Target: branch/jal -> pc+imm (mod 2^XLEN); jalr -> alu_o & ~1. jal/jalr always taken.
//  - redirect_valid registered: high exactly one cycle after an accepted taken beat, redirect_pc
//    with it; never repeats while that beat stalls at the output.
//  - is_branch beats: out_reg_write forced 0. Priority if multiple set: jalr > jal > branch.
//  - out_* stable while out_valid & !out_ready (no payload change, no drop).
//  - flush: synchronous; clears out_valid and all held entries next edge; beat offered same
//    cycle dropped, no redirect. flush beats simultaneous accept and emit.
//  - Reset mid-operation: async clear of all valid bits and redirect_valid; no partial beat.
// CONFIGURATION
//  EX_MEM_SKID_EN defined: 2-entry skid (main+skid); in_ready is a flop = !skid_valid, no
//    combinational path out_ready->in_ready; full throughput under back-pressure, 1-beat slack.
//  EX_MEM_SKID_EN undefined: single register; in_ready = !out_valid | out_ready (combinational).
//  Ordering, redirect timing, and flush semantics identical in both builds.
// STRUCTURE
//  Shared package risc_pkg: ex_mem_t payload struct; BR_BEQ..BR_BGEU funct3 localparams.
//  Sub-module br_resolve (combinational): funct3, alu_o[0], alu_zero, jump flags, pc, imm ->
//    taken, target, link (pc+4). Stage holds only handshake, storage, and redirect flop.
// TESTING
//  1 Reset: rst_n low mid-stream -> out_valid=0, redirect_valid=0 immediately; in_ready=1 after.
//  2 BEQ pc=0x100 imm=0x20 alu_zero=1 -> redirect_valid 1 cycle, redirect_pc=0x120;
//    alu_zero=0 -> no redirect.
//  3 JALR alu_o=0x2003 pc=0x40 rd=1 -> redirect_pc=0x2002, out_result=0x44, out_reg_write=1.
//  4 BLTU alu_o=1 / BGEU alu_o=1 -> taken / not taken; BNE 0x80 imm=-8 taken -> redirect_pc=0x78.
//  5 out_ready low 5 cycles, 4 back-to-back beats -> no loss/reorder, payload stable; with
//    EX_MEM_SKID_EN in_ready drops only after 2 beats held.
//  6 flush with 2 held beats and a taken JAL offered -> out_valid=0 next cycle, no redirect.

Source files
------------

// File: rtl/risc_pkg.sv
// ============================================================================
// Module : risc_pkg
// Brief  : Shared EX/MEM payload type, branch funct3 codes, condition helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package risc_pkg;

   localparam int c_xlen       = 32;
   localparam int c_reg_addr_w = 5;

   localparam logic [2:0] BR_BEQ  = 3'b000;
   localparam logic [2:0] BR_BNE  = 3'b001;
   localparam logic [2:0] BR_BLT  = 3'b100;
   localparam logic [2:0] BR_BGE  = 3'b101;
   localparam logic [2:0] BR_BLTU = 3'b110;
   localparam logic [2:0] BR_BGEU = 3'b111;

   typedef struct packed {
      logic [c_xlen-1:0]       result;
      logic [c_xlen-1:0]       store_data;
      logic [c_reg_addr_w-1:0] rd;
      logic                    mem_read;
      logic                    mem_write;
      logic                    reg_write;
   } ex_mem_t;

   // The ALU has already done SUB/SLT/SLTU, so only the zero flag and bit 0 matter.
   function automatic logic br_cond_taken(input logic [2:0] funct3,
                                          input logic       alu_lsb,
                                          input logic       alu_zero);
      logic taken;
      taken = 1'b0;
      case (funct3)
         BR_BEQ:           taken = alu_zero;
         BR_BNE:           taken = ~alu_zero;
         BR_BLT, BR_BLTU:  taken = alu_lsb;
         BR_BGE, BR_BGEU:  taken = ~alu_lsb;
         default:          taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

`default_nettype wire

// File: rtl/br_resolve.sv
// ============================================================================
// Module : br_resolve
// Brief  : Combinational branch/jump resolution: taken flag, target, link.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module br_resolve
   import risc_pkg::*;
#(
   parameter int XLEN = c_xlen
) (
   input  logic [2:0]      br_funct3,
   input  logic [XLEN-1:0] alu_o,
   input  logic            alu_zero,
   input  logic            is_branch,
   input  logic            is_jal,
   input  logic            is_jalr,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] imm,
   output logic            taken,
   output logic [XLEN-1:0] target,
   output logic [XLEN-1:0] link
);

   // jalr outranks jal, which outranks a conditional branch.
   always_comb begin
      taken  = 1'b0;
      target = pc + imm;
      link   = pc + XLEN'(4);
      if (is_jalr) begin
         taken  = 1'b1;
         target = {alu_o[XLEN-1:1], 1'b0};
      end else if (is_jal) begin
         taken  = 1'b1;
      end else if (is_branch) begin
         taken  = br_cond_taken(br_funct3, alu_o[0], alu_zero);
      end
   end

endmodule

`default_nettype wire

// File: rtl/ex_mem_stage.sv
// ============================================================================
// Module : ex_mem_stage
// Brief  : EX->MEM pipeline register with branch redirect and valid/ready.
//          Define EX_MEM_SKID_EN for a 2-entry skid with a registered in_ready.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ex_mem_stage
   import risc_pkg::*;
#(
   parameter int XLEN       = c_xlen,
   parameter int REG_ADDR_W = c_reg_addr_w
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [XLEN-1:0]       alu_o,
   input  logic                  alu_zero,
   input  logic [XLEN-1:0]       pc,
   input  logic [XLEN-1:0]       imm,
   input  logic [XLEN-1:0]       rs2_data,
   input  logic [REG_ADDR_W-1:0] rd,
   input  logic [2:0]            br_funct3,
   input  logic                  is_branch,
   input  logic                  is_jal,
   input  logic                  is_jalr,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic                  reg_write,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [XLEN-1:0]       out_result,
   output logic [XLEN-1:0]       out_store_data,
   output logic [REG_ADDR_W-1:0] out_rd,
   output logic                  out_mem_read,
   output logic                  out_mem_write,
   output logic                  out_reg_write,
   output logic                  redirect_valid,
   output logic [XLEN-1:0]       redirect_pc
);

   logic            w_taken;
   logic [XLEN-1:0] w_target;
   logic [XLEN-1:0] w_link;
   logic            w_accept;
   logic            w_emit;
   ex_mem_t         w_in_beat;
   ex_mem_t         r_main;
   logic            r_main_valid;
   logic            r_redirect_valid;
   logic [XLEN-1:0] r_redirect_pc;

   br_resolve #(.XLEN(XLEN)) u_br_resolve (
      .br_funct3 (br_funct3),
      .alu_o     (alu_o),
      .alu_zero  (alu_zero),
      .is_branch (is_branch),
      .is_jal    (is_jal),
      .is_jalr   (is_jalr),
      .pc        (pc),
      .imm       (imm),
      .taken     (w_taken),
      .target    (w_target),
      .link      (w_link)
   );

   assign w_accept = in_valid & in_ready & ~flush;
   assign w_emit   = r_main_valid & out_ready;

   // A pure branch never writes a register; any jump keeps its link write.
   always_comb begin
      w_in_beat            = '0;
      w_in_beat.result     = (is_jal | is_jalr) ? w_link : alu_o;
      w_in_beat.store_data = rs2_data;
      w_in_beat.rd         = rd;
      w_in_beat.mem_read   = mem_read;
      w_in_beat.mem_write  = mem_write;
      w_in_beat.reg_write  = reg_write & ~(is_branch & ~is_jal & ~is_jalr);
   end

`ifdef EX_MEM_SKID_EN
   ex_mem_t r_skid;
   logic    r_skid_valid;

   // The skid slot only fills when main is held, so in_ready never sees out_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
         r_main       <= '0;
         r_skid       <= '0;
      end else if (flush) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (w_accept) begin
         if (!r_main_valid || w_emit) begin
            r_main       <= w_in_beat;
            r_main_valid <= 1'b1;
         end else begin
            r_skid       <= w_in_beat;
            r_skid_valid <= 1'b1;
         end
      end else if (w_emit) begin
         if (r_skid_valid) begin
            r_main       <= r_skid;
            r_skid_valid <= 1'b0;
         end else begin
            r_main_valid <= 1'b0;
         end
      end
   end

   assign in_ready = ~r_skid_valid;
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main_valid <= 1'b0;
         r_main       <= '0;
      end else if (flush) begin
         r_main_valid <= 1'b0;
      end else if (w_accept) begin
         r_main       <= w_in_beat;
         r_main_valid <= 1'b1;
      end else if (w_emit) begin
         r_main_valid <= 1'b0;
      end
   end

   assign in_ready = ~r_main_valid | out_ready;
`endif

   // Tied to acceptance, so a stalled beat cannot re-fire its redirect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
      end else begin
         r_redirect_valid <= w_accept & w_taken;
         if (w_accept && w_taken) begin
            r_redirect_pc <= w_target;
         end
      end
   end

   assign out_valid      = r_main_valid;
   assign out_result     = r_main.result;
   assign out_store_data = r_main.store_data;
   assign out_rd         = r_main.rd;
   assign out_mem_read   = r_main.mem_read;
   assign out_mem_write  = r_main.mem_write;
   assign out_reg_write  = r_main.reg_write;
   assign redirect_valid = r_redirect_valid;
   assign redirect_pc    = r_redirect_pc;

endmodule

`default_nettype wire
